// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/response bundle for the iterative multiply/divide unit.
// The requester drives the operation and operands and takes results (master);
// the unit consumes requests and presents registered results (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, rs1, rs2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, rs1, rs2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M-style multiply/divide unit.
// One radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
// per cycle for WIDTH cycles, working on operand magnitudes, with sign
// correction folded into the final step that loads the result register.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed
// divide overflow and multiply by zero skip the iterative phase and deliver
// their result one edge after acceptance.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Iteration state. For multiply lo_reg holds the shrinking multiplier and
  // hi_reg the growing partial product; for divide lo_reg holds the dividend
  // being shifted out / quotient being shifted in and hi_reg the remainder.
  logic [CW-1:0]    count_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             div_zero_reg;

  // Request decode
  logic             accept;
  logic             a_signed;
  logic             b_signed;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             early_hit;
  logic [WIDTH-1:0] early_val;

  // Step datapath
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   hi_step;
  logic [WIDTH-1:0]   lo_step;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   final_val;
  logic               last_step;

  assign accept    = (state_reg == IDLE) && bus.in_valid && !flush;
  assign last_step = (count_reg == CW'(1));

  // Hold in_ready low while reset is asserted so nothing is taken during reset.
  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;

  // Operand signedness and magnitudes for the incoming request
  always_comb begin
    a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
               (bus.op == 3'b100) || (bus.op == 3'b110);
    b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    neg_a    = a_signed && bus.rs1[WIDTH-1];
    neg_b    = b_signed && bus.rs2[WIDTH-1];
    mag_a    = neg_a ? -bus.rs1 : bus.rs1;
    mag_b    = neg_b ? -bus.rs2 : bus.rs2;
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Detect operations whose result is known without iterating
  always_comb begin
    early_hit = 1'b0;
    early_val = '0;
    if (!bus.op[2]) begin
      if ((bus.rs1 == '0) || (bus.rs2 == '0)) begin
        early_hit = 1'b1;
      end
    end else if (bus.rs2 == '0) begin
      early_hit = 1'b1;
      early_val = bus.op[1] ? bus.rs1 : '1;
    end else if (!bus.op[0] && (bus.rs1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (bus.rs2 == '1)) begin
      early_hit = 1'b1;
      early_val = bus.op[1] ? '0 : bus.rs1;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_val = '0;
`endif

  // One iteration step plus the sign-corrected result of the final step
  always_comb begin
    sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    shifted = {hi_reg, lo_reg[WIDTH-1]};
    diff    = shifted - {1'b0, b_reg};
    if (op_reg[2]) begin
      // A non-negative trial difference means the divisor fits: keep it.
      if (!diff[WIDTH]) begin
        hi_step = diff[WIDTH-1:0];
        lo_step = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = shifted[WIDTH-1:0];
        lo_step = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], lo_reg[WIDTH-1:1]};
    end

    prod     = {hi_step, lo_step};
    prod_fix = neg_q_reg ? -prod : prod;
    // Zero divisor: the quotient is all-ones regardless of operand signs.
    quo_fix  = div_zero_reg ? '1 : (neg_q_reg ? -lo_step : lo_step);
    rem_fix  = neg_r_reg ? -hi_step : hi_step;

    case (op_reg)
      3'b000:  final_val = prod_fix[WIDTH-1:0];
      3'b001,
      3'b010,
      3'b011:  final_val = prod_fix[2*WIDTH-1:WIDTH];
      3'b100,
      3'b101:  final_val = quo_fix;
      default: final_val = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = early_hit ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Operand capture, iteration registers and the result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg    <= '0;
      op_reg       <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else if (flush) begin
      count_reg <= '0;
    end else if (accept) begin
      op_reg       <= bus.op;
      neg_q_reg    <= neg_a ^ neg_b;
      neg_r_reg    <= neg_a;
      div_zero_reg <= bus.op[2] && (bus.rs2 == '0);
      hi_reg       <= '0;
      lo_reg       <= bus.op[2] ? mag_a : mag_b;
      b_reg        <= bus.op[2] ? mag_b : mag_a;
      if (early_hit) begin
        count_reg  <= '0;
        result_reg <= early_val;
      end else begin
        count_reg  <= CW'(WIDTH);
      end
    end else if (state_reg == BUSY) begin
      hi_reg    <= hi_step;
      lo_reg    <= lo_step;
      count_reg <= count_reg - CW'(1);
      if (last_step) begin
        result_reg <= final_val;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed bench for muldiv_unit (WIDTH=32) with an
// arithmetic reference model, a per-cycle result monitor and hand-computed
// literal expectations for every directed vector.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs [18] = '{
    '{3'd0, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFF9},
    '{3'd1, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF},
    '{3'd3, 32'hFFFFFFFF, 32'd7,        32'h00000006},
    '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
    '{3'd5, 32'd100,      32'd7,        32'd14},
    '{3'd7, 32'd100,      32'd7,        32'd2},
    '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF},
    '{3'd6, 32'd5,        32'd0,        32'd5},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
    '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF},
    '{3'd7, 32'd5,        32'd0,        32'd5},
    '{3'd0, 32'd0,        32'h00001234, 32'd0},
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
    '{3'd0, 32'd12345,    32'd6789,     32'h04FED79D},
    '{3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2},
    '{3'd6, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE}
  };

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference behaviour from plain 64-bit arithmetic
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint q;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return '0;
        q = sa % sb;
        return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic bit early(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[2]) return (a == 0) || (b == 0);
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF;
`else
    return 1'b0;
`endif
  endfunction

  // Result monitor: every cycle a result is offered it must match the model
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0 result=0x%0h", bus.result);
      end else begin
        check("monitor_result", bus.result, exp_q[0]);
        check("monitor_in_ready_low", bus.in_ready, 1'b0);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_ready_wait"}, bus.in_ready, 1'b1);
  endtask

  // Issue one request, check latency and literal result, optionally stall, consume
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] lit, input int hold);
    int lat;
    int exp_lat;
    wait_ready(name);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.rs1 = a;
    bus.rs2 = b;
    @(posedge clk);
    exp_q.push_back(model(op, a, b));
    #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom);
    bus.rs1 = $urandom;
    bus.rs2 = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lat = early(op, a, b) ? 1 : W + 1;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, bus.result, lit);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_out_valid"}, bus.out_valid, 1'b1);
      check({name, "_hold_in_ready"}, bus.in_ready, 1'b0);
      check({name, "_hold_result"}, bus.result, lit);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, "_in_ready_after"}, bus.in_ready, 1'b1);
    check({name, "_out_valid_after"}, bus.out_valid, 1'b0);
    $display("txn %s op=%0d rs1=0x%08h rs2=0x%08h result=0x%08h latency=%0d",
             name, op, a, b, lit, lat);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 3'd0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1'b0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", bus.in_ready, 1'b1);

    // Model pinned to hand values
    check("model_mul", model(3'd0, 32'hFFFFFFFF, 32'd7), 32'hFFFFFFF9);
    check("model_div_ovf", model(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    check("model_rem_neg", model(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    foreach (vecs[k]) begin
      do_op($sformatf("vec%0d", k), vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].r, 0);
    end

    // Consumer stall of 10 cycles
    do_op("stall", 3'd5, 32'd100, 32'd7, 32'd14, 10);

    // Flush in the middle of an iterative operation
    wait_ready("flush");
    bus.in_valid = 1'b1;
    bus.op = 3'd0;
    bus.rs1 = 32'd12345;
    bus.rs2 = 32'd6789;
    @(posedge clk);
    exp_q.push_back(model(3'd0, 32'd12345, 32'd6789));
    #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("flush_busy_in_ready", bus.in_ready, 1'b0);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    check("flush_in_ready", bus.in_ready, 1'b1);
    check("flush_out_valid", bus.out_valid, 1'b0);
    $display("txn flush op=0 rs1=0x%08h rs2=0x%08h aborted", 32'd12345, 32'd6789);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_result", bus.out_valid, 1'b0);
    do_op("after_flush", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0);

    // Reset in the middle of an iterative operation
    wait_ready("rst_mid");
    bus.in_valid = 1'b1;
    bus.op = 3'd5;
    bus.rs1 = 32'd100;
    bus.rs2 = 32'd7;
    @(posedge clk);
    exp_q.push_back(model(3'd5, 32'd100, 32'd7));
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_out_valid", bus.out_valid, 1'b0);
    check("rst_mid_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold_in_ready", bus.in_ready, 1'b0);
    check("rst_hold_result", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_in_ready", bus.in_ready, 1'b1);
    check("rst_release_out_valid", bus.out_valid, 1'b0);
    check("rst_release_result", bus.result, 32'd0);
    $display("txn rst_mid op=5 rs1=0x%08h rs2=0x%08h aborted", 32'd100, 32'd7);
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_result", bus.out_valid, 1'b0);
    do_op("after_rst", 3'd7, 32'd100, 32'd7, 32'd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values: even, 8..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous abort of any operation in flight.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-007 The block SHALL have port op, input, 3 bits: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-008 The block SHALL have ports rs1 and rs2, input, WIDTH bits each: operand A (multiplicand/dividend) and operand B (multiplier/divisor).
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: the registered result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 IDLE->BUSY SHALL occur on the edge with in_valid&in_ready; op, rs1 and rs2 are captured on that edge and are not sampled afterwards.
REQ-014 BUSY SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for exactly WIDTH steps tracked by a down-counter.
REQ-015 BUSY->DONE SHALL occur on the edge completing step WIDTH, so out_valid rises exactly WIDTH+1 edges after the accepting edge.
REQ-016 DONE->IDLE SHALL occur on the edge with out_ready=1; result holds stable while out_valid=1 and out_ready=0.
REQ-017 A new request SHALL NOT be accepted in the cycle a result is consumed (in_ready=0 in DONE).
REQ-018 Signed operations SHALL operate on magnitudes and apply sign correction at DONE entry: MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned.
REQ-019 MUL SHALL return the low WIDTH bits of the 2*WIDTH-bit product; MULH/MULHSU/MULHU SHALL return the high WIDTH bits.
REQ-020 DIV/REM SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-021 Divide by zero SHALL return quotient all-ones for DIV and DIVU, and remainder = rs1 for REM and REMU.
REQ-022 Signed overflow (rs1 = most-negative, rs2 = -1) SHALL return DIV = rs1 and REM = 0.
REQ-023 flush=1 SHALL force IDLE on the next edge from any state, discard any pending result, and take priority over in_valid and out_ready in the same cycle.
REQ-024 result SHALL be a register updated only on DONE entry.

Reset
REQ-025 While rst=1: state=IDLE, counter=0, result=0, internal accumulators=0; out_valid=0, and in_ready=1 in the cycle after rst deasserts.
REQ-026 rst asserted mid-operation SHALL abort immediately, with no result delivered.

Configuration
REQ-027 Macro MULDIV_EARLY_OUT_EN: when defined, divide-by-zero, signed overflow, and multiply with either operand zero SHALL bypass BUSY (IDLE->DONE on the accepting edge, out_valid after 1 edge, same values as REQ-019 to REQ-022).
REQ-028 Without MULDIV_EARLY_OUT_EN, every operation SHALL take the full WIDTH+1 edges.

Verification (WIDTH=32)
REQ-029 MUL rs1=0xFFFFFFFF (-1), rs2=7 -> result 0xFFFFFFF9 and out_valid 33 edges after accept; MULH with the same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
REQ-030 DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-031 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM with the same operands -> 0. With MULDIV_EARLY_OUT_EN these arrive after 1 edge; without it, after 33.
REQ-032 Hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 Assert flush at BUSY step 10 -> IDLE next edge, no out_valid pulse; the next request (MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF) completes correctly.
REQ-034 Assert rst mid-BUSY -> out_valid=0 and in_ready=0 while rst=1, IDLE with result=0 after release.
